// File: rtl/mem_load_ctrl_pkg.sv
// Shared definitions for the M-stage load unit: load op codes, access size
// encodings, FSM state encoding and small op-decode helpers.
// Optional feature macro: LOAD_LWLR_EN (LWL/LWR become loads when defined).
package mem_load_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unaligned-word merge ops: they always fetch the whole aligned word.
    function automatic logic is_lwlr(input logic [7:0] op);
        return (op == EXE_LWL_OP) || (op == EXE_LWR_OP);
    endfunction

    // Ops that start a memory read in this build.
    function automatic logic is_load(input logic [7:0] op);
        logic r;
        r = (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
            (op == EXE_LHU_OP) || (op == EXE_LW_OP);
`ifdef LOAD_LWLR_EN
        r = r || is_lwlr(op);
`endif
        return r;
    endfunction

    // Bus access size for an op; anything that is not a byte or half is a word.
    function automatic logic [1:0] load_size(input logic [7:0] op);
        logic [1:0] s;
        case (op)
            EXE_LB_OP, EXE_LBU_OP: s = SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP: s = SIZE_HALF;
            default:               s = SIZE_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_load_ctrl_align.sv
// Combinational load result former: picks the addressed byte/halfword out of
// the read word and sign/zero extends it. With LOAD_LWLR_EN defined it also
// merges the read word with the old rt value for LWL/LWR.
module mem_load_ctrl_align
    import mem_load_ctrl_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

`ifndef LOAD_LWLR_EN
    // rt_old only feeds the LWL/LWR merge, which is absent in this build.
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old;
`endif

    // Lane select and extension by op.
    always_comb begin
        byte_v = 8'(rdata >> {a, 3'b000});
        half_v = 16'(rdata >> {a[1], 4'b0000});
        result = rdata;
        case (op)
            EXE_LB_OP:  result = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: result = {24'h0, byte_v};
            EXE_LH_OP:  result = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: result = {16'h0, half_v};
`ifdef LOAD_LWLR_EN
            // Low a+1 bytes of rdata go to the top; rt_old keeps the rest.
            EXE_LWL_OP: result = (rdata << {~a, 3'b000}) |
                                 (rt_old & (32'hFFFF_FFFF >> (6'({a, 3'b000}) + 6'd8)));
            // High 4-a bytes of rdata go to the bottom; rt_old keeps the top a bytes.
            EXE_LWR_OP: result = (rdata >> {a, 3'b000}) |
                                 (rt_old & ~(32'hFFFF_FFFF >> {a, 3'b000}));
`endif
            default:    result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_load_ctrl.sv
// M-stage load unit. Issues one read over the req/addr_ok/data_ok handshake,
// stalls the pipeline until the data returns, and registers the aligned,
// extended result with a one-cycle ld_doneM pulse.
// Handshake: data_req stays high until the cycle data_addr_ok is seen; the
// read data is accepted in the first later cycle with data_data_ok high.
// A flushed access that was already accepted is drained (discarded) before
// the unit returns to IDLE, so requests never overlap.
// Optional feature macro: LOAD_LWLR_EN.
module mem_load_ctrl
    import mem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_validM,
    input  logic [7:0]        alucontrolM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic              adelM,
    input  logic              flushM,
    input  logic [31:0]       rt_oldM,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr,
    output logic [1:0]        data_size,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall_reqM,
    output logic [31:0]       readdataM,
    output logic              ld_doneM
);

    state_t      state;
    logic [7:0]  op_q;
    logic [1:0]  a_q;
    logic [31:0] rt_q;
    logic        discard;
    logic        start;
    logic [31:0] align_res;

    assign start = ld_validM & is_load(alucontrolM) & ~adelM & ~flushM & (state == ST_IDLE);

    // Hold the pipeline from the start cycle until the access has completed or drained.
    assign stall_reqM = start | (state == ST_REQ) | (state == ST_WAIT);

    mem_load_ctrl_align u_align (
        .op     (op_q),
        .a      (a_q),
        .rdata  (data_rdata),
        .rt_old (rt_q),
        .result (align_res)
    );

    // Load FSM with registered bus request and result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            op_q      <= 8'h0;
            a_q       <= 2'b00;
            rt_q      <= 32'h0;
            discard   <= 1'b0;
            data_req  <= 1'b0;
            data_addr <= '0;
            data_size <= SIZE_BYTE;
            readdataM <= 32'h0;
            ld_doneM  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ld_doneM <= 1'b0;
                    if (start) begin
                        op_q     <= alucontrolM;
                        a_q      <= aluoutM[1:0];
                        rt_q     <= rt_oldM;
                        discard  <= 1'b0;
                        data_req <= 1'b1;
                        if (is_lwlr(alucontrolM)) begin
                            data_addr <= {aluoutM[ADDR_W-1:2], 2'b00};
                            data_size <= SIZE_WORD;
                        end else begin
                            data_addr <= aluoutM;
                            data_size <= load_size(alucontrolM);
                        end
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok) begin
                        // Accepted: the data must be drained even if flushed now.
                        data_req <= 1'b0;
                        discard  <= flushM;
                        state    <= ST_WAIT;
                    end else if (flushM) begin
                        data_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        discard <= 1'b0;
                        if (discard || flushM) begin
                            state <= ST_IDLE;
                        end else begin
                            readdataM <= align_res;
                            ld_doneM  <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else if (flushM) begin
                        discard <= 1'b1;
                    end
                end
                ST_DONE: begin
                    ld_doneM <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
